// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM/WB, divider and register-file signals of the writeback stage
interface wb_stage_if #(parameter int XLEN = 32, parameter int CNT_W = 64);
  logic [XLEN-1:0] mem_data_in, ALU_res_in, pc_in;
  logic [31:0] instr_in;
  logic [4:0] addr_rd_in;
  logic [1:0] WBSel_in;
  logic regWEn_in, trapReq_in, is_jalr_in, is_div_in;
  logic div_valid;
  logic [XLEN-1:0] div_result;
  logic div_ready;
  logic rf_we;
  logic [4:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic div_busy;
  logic [4:0] div_rd;
  logic div_err;
  logic trap_out;
  logic [XLEN-1:0] trap_pc;
  logic [CNT_W-1:0] instret;
  modport master (
    output mem_data_in, ALU_res_in, pc_in, instr_in, addr_rd_in, WBSel_in,
           regWEn_in, trapReq_in, is_jalr_in, is_div_in, div_valid, div_result,
    input  div_ready, rf_we, rf_waddr, rf_wdata, div_busy, div_rd, div_err,
           trap_out, trap_pc, instret
  );
  modport slave (
    input  mem_data_in, ALU_res_in, pc_in, instr_in, addr_rd_in, WBSel_in,
           regWEn_in, trapReq_in, is_jalr_in, is_div_in, div_valid, div_result,
    output div_ready, rf_we, rf_waddr, rf_wdata, div_busy, div_rd, div_err,
           trap_out, trap_pc, instret
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: writeback mux, load formatting, late divide result path, retire count and traps
module wb_stage #(
  parameter int CNT_W = 64,
  parameter int XLEN  = 32
) (
  input logic clk,
  input logic reset,
  wb_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t state;
  logic valid, pw, div_issue;
  logic [2:0] f3;
  logic [7:0] lbyte;
  logic [15:0] lhalf;
  logic [XLEN-1:0] load, pc4, wdata, hold_buf;
  always_comb begin
    valid = bus.instr_in != 32'd0;
    pw = valid & bus.regWEn_in & !bus.trapReq_in & !bus.is_div_in;
    div_issue = valid & bus.is_div_in & bus.regWEn_in & !bus.trapReq_in;
    f3 = bus.instr_in[14:12];
    lbyte = bus.mem_data_in[{bus.ALU_res_in[1:0], 3'b000} +: 8];
    lhalf = bus.ALU_res_in[1] ? bus.mem_data_in[31:16] : bus.mem_data_in[15:0];
    load = f3 == 3'b000 ? {{(XLEN-8){lbyte[7]}}, lbyte} :
           f3 == 3'b100 ? {{(XLEN-8){1'b0}}, lbyte} :
           f3 == 3'b001 ? {{(XLEN-16){lhalf[15]}}, lhalf} :
           f3 == 3'b101 ? {{(XLEN-16){1'b0}}, lhalf} : bus.mem_data_in;
    pc4 = bus.pc_in + XLEN'(4);
    wdata = bus.is_jalr_in ? pc4 :
            bus.WBSel_in == 2'd0 ? load :
            bus.WBSel_in == 2'd2 ? pc4 : bus.ALU_res_in;
  end
  assign bus.div_ready = state == WAIT;
  assign bus.div_busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      hold_buf <= '0;
      bus.rf_we <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      bus.div_rd <= '0;
      bus.div_err <= 1'b0;
      bus.trap_out <= 1'b0;
      bus.trap_pc <= '0;
      bus.instret <= '0;
    end else begin
      // pipeline writes win the port; a divide result landing in a busy cycle waits in hold_buf
      bus.rf_we <= 1'b0;
      if (pw) begin
        bus.rf_we <= bus.addr_rd_in != 5'd0;
        bus.rf_waddr <= bus.addr_rd_in;
        bus.rf_wdata <= wdata;
      end else if (state == WAIT && bus.div_valid) begin
        bus.rf_we <= bus.div_rd != 5'd0;
        bus.rf_waddr <= bus.div_rd;
        bus.rf_wdata <= bus.div_result;
      end else if (state == HOLD) begin
        bus.rf_we <= bus.div_rd != 5'd0;
        bus.rf_waddr <= bus.div_rd;
        bus.rf_wdata <= hold_buf;
      end
      if (state == IDLE && div_issue) begin
        state <= WAIT;
        bus.div_rd <= bus.addr_rd_in;
      end else if (state == WAIT && bus.div_valid) begin
        state <= pw ? HOLD : IDLE;
        hold_buf <= bus.div_result;
      end else if (state == HOLD && !pw) begin
        state <= IDLE;
      end
      if (div_issue && state != IDLE) bus.div_err <= 1'b1;
      bus.trap_out <= valid & bus.trapReq_in;
      if (valid & bus.trapReq_in) bus.trap_pc <= bus.pc_in;
      if (valid & !bus.trapReq_in) bus.instret <= bus.instret + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: vector table, directed divide/trap/reset sequences and a randomized model check
module tb_wb_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;
  wb_stage_if #(.XLEN(32), .CNT_W(64)) bus();
  wb_stage #(.CNT_W(64), .XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mem, alu, pc;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [1:0] sel;
    logic jalr;
    logic we;
    logic [31:0] data;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    bus.mem_data_in = '0; bus.ALU_res_in = '0; bus.pc_in = '0; bus.instr_in = '0;
    bus.addr_rd_in = '0; bus.WBSel_in = '0; bus.regWEn_in = 0; bus.trapReq_in = 0;
    bus.is_jalr_in = 0; bus.is_div_in = 0; bus.div_valid = 0; bus.div_result = '0;
  endtask

  task automatic do_reset();
    clear();
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic issue_div(input logic [4:0] rd);
    clear();
    bus.instr_in = 32'h0200_4033;
    bus.is_div_in = 1;
    bus.regWEn_in = 1;
    bus.addr_rd_in = rd;
  endtask

  task automatic set_pw(input logic [4:0] rd, input logic [31:0] val);
    bus.instr_in = 32'h0000_0033;
    bus.is_div_in = 0;
    bus.regWEn_in = 1;
    bus.WBSel_in = 2'd1;
    bus.addr_rd_in = rd;
    bus.ALU_res_in = val;
  endtask

  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (off >= 2'd2 ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'd0: return b >= 32'd128 ? b - 32'd256 : b;
      3'd4: return b;
      3'd1: return h >= 32'd32768 ? h - 32'd65536 : h;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] wb_val(input logic jalr, input logic [1:0] sel, input logic [31:0] pc,
                                         input logic [31:0] alu, input logic [31:0] mem, input logic [2:0] f3);
    if (jalr || sel == 2'd2) return pc + 32'd4;
    if (sel == 2'd0) return fmt(mem, alu[1:0], f3);
    return alu;
  endfunction

  initial begin
    logic [63:0] cnt0;
    logic m_wait, m_held, m_err, valid, pw, issue, e_we, e_trap;
    logic [4:0] m_rd, e_addr;
    logic [31:0] m_buf, e_data, pc_s;
    logic [63:0] m_cnt;

    vecs[0]  = '{32'h8001_F0FE, 32'h2, 32'h0, 3'd0, 5'd1, 2'd0, 1'b0, 1'b1, 32'h0000_0001};
    vecs[1]  = '{32'h8001_F0FE, 32'h0, 32'h0, 3'd0, 5'd2, 2'd0, 1'b0, 1'b1, 32'hFFFF_FFFE};
    vecs[2]  = '{32'h8001_F0FE, 32'h2, 32'h0, 3'd5, 5'd3, 2'd0, 1'b0, 1'b1, 32'h0000_8001};
    vecs[3]  = '{32'h8001_F0FE, 32'h0, 32'h0, 3'd1, 5'd4, 2'd0, 1'b0, 1'b1, 32'hFFFF_F0FE};
    vecs[4]  = '{32'h8001_F0FE, 32'h3, 32'h0, 3'd1, 5'd5, 2'd0, 1'b0, 1'b1, 32'hFFFF_8001};
    vecs[5]  = '{32'h8001_F0FE, 32'h3, 32'h0, 3'd4, 5'd6, 2'd0, 1'b0, 1'b1, 32'h0000_0080};
    vecs[6]  = '{32'h8001_F0FE, 32'h1, 32'h0, 3'd2, 5'd7, 2'd0, 1'b0, 1'b1, 32'h8001_F0FE};
    vecs[7]  = '{32'h8001_F0FE, 32'h1, 32'h0, 3'd7, 5'd8, 2'd0, 1'b0, 1'b1, 32'h8001_F0FE};
    vecs[8]  = '{32'h0, 32'h55, 32'h0000_0100, 3'd0, 5'd1, 2'd1, 1'b1, 1'b1, 32'h0000_0104};
    vecs[9]  = '{32'h0, 32'h55, 32'hFFFF_FFFC, 3'd0, 5'd1, 2'd1, 1'b1, 1'b1, 32'h0000_0000};
    vecs[10] = '{32'h0, 32'h55, 32'h0000_0100, 3'd0, 5'd0, 2'd1, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{32'h0, 32'h55, 32'h0000_0040, 3'd0, 5'd9, 2'd2, 1'b0, 1'b1, 32'h0000_0044};
    vecs[12] = '{32'h0, 32'h1234, 32'h40, 3'd0, 5'd10, 2'd3, 1'b0, 1'b1, 32'h0000_1234};
    vecs[13] = '{32'hDEAD, 32'hCAFE_0001, 32'h40, 3'd0, 5'd11, 2'd1, 1'b0, 1'b1, 32'hCAFE_0001};

    do_reset();
    chk("rst_we", bus.rf_we, 0);
    chk("rst_instret", bus.instret, 0);
    chk("rst_busy", bus.div_busy, 0);
    chk("rst_ready", bus.div_ready, 0);
    chk("rst_trap", bus.trap_out, 0);

    foreach (vecs[i]) begin
      clear();
      bus.mem_data_in = vecs[i].mem;
      bus.ALU_res_in = vecs[i].alu;
      bus.pc_in = vecs[i].pc;
      bus.instr_in = 32'h3 | (32'(vecs[i].f3) << 12);
      bus.addr_rd_in = vecs[i].rd;
      bus.WBSel_in = vecs[i].sel;
      bus.is_jalr_in = vecs[i].jalr;
      bus.regWEn_in = 1;
      tick();
      chk($sformatf("vec%0d_we", i), bus.rf_we, vecs[i].we);
      if (vecs[i].we) begin
        chk($sformatf("vec%0d_addr", i), bus.rf_waddr, vecs[i].rd);
        chk($sformatf("vec%0d_data", i), bus.rf_wdata, vecs[i].data);
      end
    end
    clear();
    tick();
    chk("bubble_we", bus.rf_we, 0);

    // divide without collision
    do_reset();
    issue_div(5'd5);
    tick();
    chk("div_busy", bus.div_busy, 1);
    chk("div_rd", bus.div_rd, 5);
    chk("div_issue_we", bus.rf_we, 0);
    chk("div_instret", bus.instret, 1);
    clear();
    bus.div_valid = 1;
    bus.div_result = 32'd7;
    chk("div_ready", bus.div_ready, 1);
    tick();
    chk("div_wb_we", bus.rf_we, 1);
    chk("div_wb_addr", bus.rf_waddr, 5);
    chk("div_wb_data", bus.rf_wdata, 7);
    chk("div_busy_drop", bus.div_busy, 0);

    // divide colliding with pipeline writes
    issue_div(5'd5);
    tick();
    clear();
    bus.div_valid = 1;
    bus.div_result = 32'd11;
    set_pw(5'd3, 32'd9);
    tick();
    chk("col_addr", bus.rf_waddr, 3);
    chk("col_data", bus.rf_wdata, 9);
    chk("col_busy", bus.div_busy, 1);
    chk("col_ready", bus.div_ready, 0);
    clear();
    set_pw(5'd4, 32'd1);
    tick();
    chk("col_pw2", bus.rf_waddr, 4);
    set_pw(5'd6, 32'd2);
    tick();
    chk("col_pw3", bus.rf_waddr, 6);
    chk("col_busy3", bus.div_busy, 1);
    clear();
    tick();
    chk("col_wb_we", bus.rf_we, 1);
    chk("col_wb_addr", bus.rf_waddr, 5);
    chk("col_wb_data", bus.rf_wdata, 11);
    chk("col_busy_drop", bus.div_busy, 0);

    // trap
    cnt0 = bus.instret;
    clear();
    bus.instr_in = 32'h0000_0033;
    bus.trapReq_in = 1;
    bus.regWEn_in = 1;
    bus.pc_in = 32'h200;
    bus.addr_rd_in = 5'd7;
    bus.WBSel_in = 2'd1;
    tick();
    chk("trap_we", bus.rf_we, 0);
    chk("trap_out", bus.trap_out, 1);
    chk("trap_pc", bus.trap_pc, 32'h200);
    chk("trap_instret", bus.instret, cnt0);
    clear();
    tick();
    chk("trap_pulse", bus.trap_out, 0);

    // illegal second divide
    issue_div(5'd5);
    tick();
    issue_div(5'd6);
    tick();
    chk("err_set", bus.div_err, 1);
    chk("err_rd", bus.div_rd, 5);
    clear();
    bus.div_valid = 1;
    bus.div_result = 32'd3;
    tick();
    chk("err_wb_addr", bus.rf_waddr, 5);
    clear();
    tick();
    tick();
    chk("err_sticky", bus.div_err, 1);

    // reset while holding a divide result
    issue_div(5'd5);
    tick();
    clear();
    bus.div_valid = 1;
    bus.div_result = 32'd99;
    set_pw(5'd3, 32'd1);
    tick();
    chk("hold_busy", bus.div_busy, 1);
    clear();
    reset = 0;
    tick();
    chk("mr_we", bus.rf_we, 0);
    chk("mr_waddr", bus.rf_waddr, 0);
    chk("mr_wdata", bus.rf_wdata, 0);
    chk("mr_busy", bus.div_busy, 0);
    chk("mr_rd", bus.div_rd, 0);
    chk("mr_err", bus.div_err, 0);
    chk("mr_trap_pc", bus.trap_pc, 0);
    chk("mr_instret", bus.instret, 0);
    reset = 1;
    bus.div_valid = 1;
    bus.div_result = 32'd77;
    chk("mr_ready", bus.div_ready, 0);
    tick();
    chk("mr_late_we", bus.rf_we, 0);
    tick();
    chk("mr_late_we2", bus.rf_we, 0);

    // randomized run against a reference model
    do_reset();
    m_wait = 0; m_held = 0; m_err = 0; m_rd = 0; m_buf = 0; m_cnt = 0;
    for (int c = 0; c < 2000; c++) begin
      clear();
      bus.instr_in = ($urandom_range(0, 4) == 0) ? 32'h0 : ($urandom | 32'h1);
      bus.mem_data_in = $urandom;
      bus.ALU_res_in = $urandom;
      bus.pc_in = (c % 50 == 0) ? 32'hFFFF_FFFC : $urandom;
      bus.addr_rd_in = 5'($urandom);
      bus.WBSel_in = 2'($urandom);
      bus.regWEn_in = $urandom_range(0, 4) != 0;
      bus.trapReq_in = $urandom_range(0, 9) == 0;
      bus.is_jalr_in = $urandom_range(0, 7) == 0;
      bus.is_div_in = $urandom_range(0, 5) == 0;
      bus.div_valid = $urandom_range(0, 2) == 0;
      bus.div_result = $urandom;
      chk("rnd_ready", bus.div_ready, m_wait);
      chk("rnd_busy", bus.div_busy, m_wait | m_held);
      valid = bus.instr_in != 0;
      pw = valid && bus.regWEn_in && !bus.trapReq_in && !bus.is_div_in;
      issue = valid && bus.is_div_in && bus.regWEn_in && !bus.trapReq_in;
      e_we = 0; e_addr = 0; e_data = 0;
      if (pw) begin
        e_we = bus.addr_rd_in != 0;
        e_addr = bus.addr_rd_in;
        e_data = wb_val(bus.is_jalr_in, bus.WBSel_in, bus.pc_in, bus.ALU_res_in,
                        bus.mem_data_in, bus.instr_in[14:12]);
      end else if (m_wait && bus.div_valid) begin
        e_we = m_rd != 0; e_addr = m_rd; e_data = bus.div_result;
      end else if (m_held) begin
        e_we = m_rd != 0; e_addr = m_rd; e_data = m_buf;
      end
      if (issue && (m_wait || m_held)) m_err = 1;
      if (m_wait && bus.div_valid) begin
        m_wait = 0; m_held = pw; m_buf = bus.div_result;
      end else if (m_held && !pw) begin
        m_held = 0;
      end else if (!m_wait && !m_held && issue) begin
        m_wait = 1; m_rd = bus.addr_rd_in;
      end
      e_trap = valid && bus.trapReq_in;
      if (valid && !bus.trapReq_in) m_cnt = m_cnt + 1;
      pc_s = bus.pc_in;
      tick();
      chk("rnd_we", bus.rf_we, e_we);
      if (e_we) begin
        chk("rnd_addr", bus.rf_waddr, e_addr);
        chk("rnd_data", bus.rf_wdata, e_data);
      end
      chk("rnd_trap", bus.trap_out, e_trap);
      if (e_trap) chk("rnd_trap_pc", bus.trap_pc, pc_s);
      chk("rnd_instret", bus.instret, m_cnt);
      chk("rnd_err", bus.div_err, m_err);
      if (m_wait || m_held) chk("rnd_div_rd", bus.div_rd, m_rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
